// File: rtl/cache_pkg.sv
//==============================================================================
// Module   : cache_pkg
// Brief    : Shared types and default sizes for the two-way set-associative cache.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package cache_pkg;

    localparam int CACHE_TAG_W   = 8;
    localparam int CACHE_INDEX_W = 6;
    localparam int CACHE_LINE_W  = 64;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [CACHE_TAG_W-1:0]  tag;
        logic [CACHE_LINE_W-1:0] data;
    } line_t;

endpackage

`default_nettype wire

// File: rtl/cache_2way_if.sv
//==============================================================================
// Module   : cache_2way_if
// Brief    : Request/response bundle between the memory-controller FSM and the cache array.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cache_2way_if #(
    parameter int TAG_W   = 8,
    parameter int INDEX_W = 6,
    parameter int LINE_W  = 64
);
    logic [TAG_W+INDEX_W-1:0] addr;
    logic [LINE_W-1:0]        wr_data;
    logic                     wdirty;
    logic                     we;
    logic                     re;
    logic                     ready;
    logic                     hit;
    logic                     dirty;
    logic [LINE_W-1:0]        rd_data;
    logic [TAG_W-1:0]         tag_out;
    logic                     way_out;

    modport master (
        output addr, wr_data, wdirty, we, re,
        input  ready, hit, dirty, rd_data, tag_out, way_out
    );

    modport slave (
        input  addr, wr_data, wdirty, we, re,
        output ready, hit, dirty, rd_data, tag_out, way_out
    );
endinterface

`default_nettype wire

// File: rtl/cache_way_array.sv
//==============================================================================
// Module   : cache_way_array
// Brief    : One way of line storage: sync write, async indexed read, per-set clear.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_way_array #(
    parameter int TAG_W   = 8,
    parameter int INDEX_W = 6,
    parameter int LINE_W  = 64
) (
    input  wire logic               clk,
    input  wire logic               we_i,
    input  wire logic [INDEX_W-1:0] idx_i,
    input  wire logic               wdirty_i,
    input  wire logic [TAG_W-1:0]   wtag_i,
    input  wire logic [LINE_W-1:0]  wdata_i,
    input  wire logic               clr_i,
    input  wire logic [INDEX_W-1:0] clr_idx_i,
    output logic                    rvalid_o,
    output logic                    rdirty_o,
    output logic [TAG_W-1:0]        rtag_o,
    output logic [LINE_W-1:0]       rdata_o
);
    localparam int NSETS = 1 << INDEX_W;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } entry_t;

    entry_t mem_q [NSETS];

    // Clear only touches the status bits; tag/data are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            mem_q[clr_idx_i].valid <= 1'b0;
            mem_q[clr_idx_i].dirty <= 1'b0;
        end else if (we_i) begin
            mem_q[idx_i] <= '{valid: 1'b1, dirty: wdirty_i, tag: wtag_i, data: wdata_i};
        end
    end

    assign rvalid_o = mem_q[idx_i].valid;
    assign rdirty_o = mem_q[idx_i].dirty;
    assign rtag_o   = mem_q[idx_i].tag;
    assign rdata_o  = mem_q[idx_i].data;

endmodule

`default_nettype wire

// File: rtl/cache_2way.sv
//==============================================================================
// Module   : cache_2way
// Brief    : Two-way set-associative line store with 1-bit LRU and post-reset sweep.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_2way
    import cache_pkg::*;
#(
    parameter int TAG_W   = CACHE_TAG_W,
    parameter int INDEX_W = CACHE_INDEX_W,
    parameter int LINE_W  = CACHE_LINE_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cache_2way_if.slave bus
);
    localparam int NSETS = 1 << INDEX_W;

    state_t              state_q;
    logic [INDEX_W:0]    cnt_q;
    logic [INDEX_W:0]    cnt_d;
    logic                ready_q;
    logic [NSETS-1:0]    lru_q;
    logic                hit_q;
    logic                dirty_q;
    logic                way_q;
    logic [LINE_W-1:0]   rd_data_q;
    logic [TAG_W-1:0]    tag_out_q;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_rvalid;
    logic [1:0]          w_rdirty;
    logic [1:0]          w_match;
    logic [1:0]          w_way_we;
    logic [TAG_W-1:0]    w_rtag  [2];
    logic [LINE_W-1:0]   w_rdata [2];
    logic                w_hit;
    logic                w_sel;
    logic                w_req;
    logic                w_wr;
    logic                w_clr;

    assign w_idx = bus.addr[INDEX_W-1:0];
    assign w_tag = bus.addr[TAG_W+INDEX_W-1:INDEX_W];
    assign w_req = ready_q & (bus.re | bus.we);
    assign w_wr  = ready_q & bus.we;
    assign w_clr = (state_q == ST_INIT);
    assign cnt_d = cnt_q + 1'b1;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_way
            assign w_way_we[g] = w_wr && (w_sel == 1'(g));
            assign w_match[g]  = w_rvalid[g] && (w_rtag[g] == w_tag);

            cache_way_array #(
                .TAG_W   (TAG_W),
                .INDEX_W (INDEX_W),
                .LINE_W  (LINE_W)
            ) u_way (
                .clk       (clk),
                .we_i      (w_way_we[g]),
                .idx_i     (w_idx),
                .wdirty_i  (bus.wdirty),
                .wtag_i    (w_tag),
                .wdata_i   (bus.wr_data),
                .clr_i     (w_clr),
                .clr_idx_i (cnt_q[INDEX_W-1:0]),
                .rvalid_o  (w_rvalid[g]),
                .rdirty_o  (w_rdirty[g]),
                .rtag_o    (w_rtag[g]),
                .rdata_o   (w_rdata[g])
            );
        end
    endgenerate

    assign w_hit = |w_match;

    // Hit way first, then the first empty way, then the LRU way.
    always_comb begin
        w_sel = 1'b0;
        if (w_match[1])       w_sel = 1'b1;
        else if (w_match[0])  w_sel = 1'b0;
        else if (!w_rvalid[0]) w_sel = 1'b0;
        else if (!w_rvalid[1]) w_sel = 1'b1;
        else                  w_sel = lru_q[w_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            hit_q     <= 1'b0;
            dirty_q   <= 1'b0;
            way_q     <= 1'b0;
            rd_data_q <= '0;
            tag_out_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    lru_q[cnt_q[INDEX_W-1:0]] <= 1'b0;
                    cnt_q <= cnt_d;
                    // Counter MSB rises once the last set has been cleared.
                    if (cnt_d[INDEX_W]) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_req) begin
                        hit_q     <= w_hit;
                        dirty_q   <= w_rvalid[w_sel] & w_rdirty[w_sel];
                        way_q     <= w_sel;
                        rd_data_q <= w_rdata[w_sel];
                        tag_out_q <= w_rtag[w_sel];
                        if (bus.we || w_hit) lru_q[w_idx] <= ~w_sel;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.hit     = hit_q;
    assign bus.dirty   = dirty_q;
    assign bus.way_out = way_q;
    assign bus.rd_data = rd_data_q;
    assign bus.tag_out = tag_out_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_2way.sv
//==============================================================================
// Module   : tb_cache_2way
// Brief    : Self-checking bench for cache_2way against a per-set behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cache_2way;
    localparam int TW = 8;
    localparam int IW = 6;
    localparam int LW = 64;
    localparam int NS = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_2way_if #(.TAG_W(TW), .INDEX_W(IW), .LINE_W(LW)) bus ();

    cache_2way #(.TAG_W(TW), .INDEX_W(IW), .LINE_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: per set, two slots plus the most-recently-used slot number.
    bit          m_valid [2][NS];
    bit          m_dirty [2][NS];
    bit          m_known [2][NS];
    logic [7:0]  m_tag   [2][NS];
    logic [63:0] m_data  [2][NS];
    int          m_mru   [NS];
    bit          m_ready;
    int          m_sweep;

    bit          e_ready, e_hit, e_dirty, e_way, e_known;
    logic [63:0] e_data;
    logic [7:0]  e_tag;

    function automatic logic [13:0] mk(int t, int s);
        return 14'(t * NS + s);
    endfunction

    task automatic model_step(bit r, bit rd, bit wr, logic [13:0] a, logic [63:0] d, bit wd);
        int s, t, w;
        if (r) begin
            m_ready = 0; m_sweep = 0;
            e_ready = 0; e_hit = 0; e_dirty = 0; e_way = 0;
            e_data = '0; e_tag = '0; e_known = 1;
            for (int i = 0; i < NS; i++) begin
                m_valid[0][i] = 0; m_valid[1][i] = 0;
                m_dirty[0][i] = 0; m_dirty[1][i] = 0;
                m_mru[i] = 1;
            end
            return;
        end
        if (!m_ready) begin
            m_sweep++;
            if (m_sweep == NS) m_ready = 1;
            e_ready = m_ready;
            return;
        end
        if (!(rd || wr)) return;
        s = int'(a) % NS;
        t = int'(a) / NS;
        w = -1;
        for (int k = 0; k < 2; k++)
            if (m_valid[k][s] && int'(m_tag[k][s]) == t) w = k;
        e_hit = (w >= 0);
        if (w < 0) begin
            if (!m_valid[0][s])      w = 0;
            else if (!m_valid[1][s]) w = 1;
            else                     w = 1 - m_mru[s];
        end
        e_way   = w[0];
        e_dirty = m_valid[w][s] && m_dirty[w][s];
        e_known = m_known[w][s];
        e_data  = m_data[w][s];
        e_tag   = m_tag[w][s];
        if (wr) begin
            m_valid[w][s] = 1;
            m_dirty[w][s] = wd;
            m_known[w][s] = 1;
            m_tag[w][s]   = 8'(t);
            m_data[w][s]  = d;
            m_mru[s]      = w;
        end else if (e_hit) begin
            m_mru[s] = w;
        end
    endtask

    task automatic cyc(bit r, bit rd, bit wr, logic [13:0] a, logic [63:0] d, bit wd);
        rst = r; bus.re = rd; bus.we = wr; bus.addr = a; bus.wr_data = d; bus.wdirty = wd;
        @(posedge clk);
        model_step(r, rd, wr, a, d, wd);
        #1;
        check_eq("ready",   bus.ready,   e_ready);
        check_eq("hit",     bus.hit,     e_hit);
        check_eq("dirty",   bus.dirty,   e_dirty);
        check_eq("way_out", bus.way_out, e_way);
        if (e_known) begin
            check_eq("rd_data", bus.rd_data, e_data);
            check_eq("tag_out", bus.tag_out, e_tag);
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, '0, '0, 0);
    endtask

    task automatic noise(bit r);
        cyc(r, 1'($urandom), 1'($urandom), 14'($urandom), {$urandom, $urandom}, 1'($urandom));
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            m_known[0][i] = 0; m_known[1][i] = 0;
            m_tag[0][i] = '0; m_tag[1][i] = '0;
            m_data[0][i] = '0; m_data[1][i] = '0;
        end
        rst = 1; bus.re = 0; bus.we = 0; bus.addr = '0; bus.wr_data = '0; bus.wdirty = 0;

        // Reset sweep
        cyc(1, 0, 0, '0, '0, 0);
        cyc(1, 0, 0, '0, '0, 0);
        check_eq("rst_rd_data", bus.rd_data, 64'h0);
        for (int i = 1; i <= NS; i++) begin
            idle();
            if (i == NS - 1) check_eq("sweep_ready_low", bus.ready, 1'b0);
            if (i == NS)     check_eq("sweep_ready_high", bus.ready, 1'b1);
        end

        // Fill and hit
        cyc(0, 0, 1, 14'h0123, 64'hDEAD_BEEF_0000_0001, 0);
        check_eq("fill_hit", bus.hit, 1'b0);
        check_eq("fill_way", bus.way_out, 1'b0);
        cyc(0, 1, 0, 14'h0123, '0, 0);
        check_eq("rd_hit", bus.hit, 1'b1);
        check_eq("rd_data_fill", bus.rd_data, 64'hDEAD_BEEF_0000_0001);

        // Second way and LRU
        cyc(0, 0, 1, mk(4, 'h23), 64'hA0A0_0000_0000_0004, 0);
        check_eq("ovr_hit", bus.hit, 1'b1);
        cyc(0, 0, 1, mk(5, 'h23), 64'hB0B0_0000_0000_0005, 0);
        check_eq("w5_way", bus.way_out, 1'b1);
        cyc(0, 1, 0, mk(4, 'h23), '0, 0);
        check_eq("r4_way", bus.way_out, 1'b0);
        cyc(0, 0, 1, mk(6, 'h23), 64'hC0C0_0000_0000_0006, 1);
        check_eq("w6_hit", bus.hit, 1'b0);
        check_eq("w6_way", bus.way_out, 1'b1);
        check_eq("w6_tag_out", bus.tag_out, 8'h05);

        // Dirty eviction
        cyc(0, 1, 0, mk(4, 'h23), '0, 0);
        cyc(0, 1, 0, mk(7, 'h23), '0, 0);
        check_eq("evict_hit", bus.hit, 1'b0);
        check_eq("evict_dirty", bus.dirty, 1'b1);
        check_eq("evict_tag", bus.tag_out, 8'h06);
        check_eq("evict_data", bus.rd_data, 64'hC0C0_0000_0000_0006);

        // Simultaneous re and we
        cyc(0, 1, 1, mk(4, 'h23), 64'h1234_5678_9ABC_DEF0, 1);
        check_eq("rw_hit", bus.hit, 1'b1);
        cyc(0, 1, 0, mk(4, 'h23), '0, 0);
        check_eq("rw_data", bus.rd_data, 64'h1234_5678_9ABC_DEF0);
        check_eq("rw_dirty", bus.dirty, 1'b1);

        // Reset mid-traffic, then mid-sweep at cycle 30, with request noise
        noise(1);
        for (int i = 0; i < 30; i++) noise(0);
        noise(1);
        for (int i = 1; i <= NS; i++) begin
            if (i < NS) noise(0); else idle();
            if (i == NS - 1) check_eq("resweep_low", bus.ready, 1'b0);
            if (i == NS - 1) check_eq("resweep_hit0", bus.hit, 1'b0);
        end
        check_eq("resweep_high", bus.ready, 1'b1);
        cyc(0, 1, 0, mk(4, 'h23), '0, 0);
        check_eq("post_rst_miss", bus.hit, 1'b0);

        // Randomised traffic on a few conflicting sets
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (i == 1500) begin
                cyc(1, 0, 0, '0, '0, 0);
                for (int j = 0; j < NS; j++) noise(0);
            end else if (op < 2) begin
                idle();
            end else begin
                cyc(0, op >= 5, op < 7 || op == 9,
                    mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)) * 21),
                    {$urandom, $urandom}, 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
